// File: rtl/ysyx_csr_if.sv
// ysyx_csr_if: EXU-side CSR request/trap bus and the CSR state it exposes back.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
interface ysyx_csr_if #(parameter int BIT_W = `YSYX_W_WIDTH, parameter int R_W = 12);
  logic             exu_valid;
  logic [1:0]       csr_op;
  logic [R_W-1:0]   addr;
  logic [BIT_W-1:0] wsrc;
  logic             trap_valid;
  logic [BIT_W-1:0] trap_cause;
  logic [BIT_W-1:0] trap_pc;
  logic [BIT_W-1:0] trap_tval;
  logic             mret_valid;
  logic [BIT_W-1:0] rdata_o;
  logic             illegal_o;
  logic [BIT_W-1:0] mtvec_o;
  logic [BIT_W-1:0] mepc_o;
  logic             mie_o;
  modport master(output exu_valid, csr_op, addr, wsrc, trap_valid, trap_cause, trap_pc, trap_tval,
                 mret_valid, input rdata_o, illegal_o, mtvec_o, mepc_o, mie_o);
  modport slave(input exu_valid, csr_op, addr, wsrc, trap_valid, trap_cause, trap_pc, trap_tval,
                mret_valid, output rdata_o, illegal_o, mtvec_o, mepc_o, mie_o);
endinterface

// File: rtl/ysyx_csr_unit.sv
// ysyx_csr_unit: machine-mode CSR file with RMW ops, trap entry/mret and WARL masking.
// Optional 64-bit mcycle/minstret counters enabled by defining YSYX_CSR_COUNTERS_EN.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif
module ysyx_csr_unit #(
  parameter int               BIT_W         = `YSYX_W_WIDTH,
  parameter int               R_W           = 12,
  parameter logic [BIT_W-1:0] RESET_VAL     = '0,
  parameter logic [BIT_W-1:0] MVENDORID_VAL = BIT_W'(32'h79737978),
  parameter logic [BIT_W-1:0] MARCHID_VAL   = BIT_W'(32'h015fde77)
) (
  input logic        clk,
  input logic        rst,
  ysyx_csr_if.slave  bus
);
  localparam logic [R_W-1:0] A_MSTATUS   = R_W'(12'h300);
  localparam logic [R_W-1:0] A_MTVEC     = R_W'(12'h305);
  localparam logic [R_W-1:0] A_MSCRATCH  = R_W'(12'h340);
  localparam logic [R_W-1:0] A_MEPC      = R_W'(12'h341);
  localparam logic [R_W-1:0] A_MCAUSE    = R_W'(12'h342);
  localparam logic [R_W-1:0] A_MTVAL     = R_W'(12'h343);
  localparam logic [R_W-1:0] A_MVENDORID = R_W'(12'hF11);
  localparam logic [R_W-1:0] A_MARCHID   = R_W'(12'hF12);
`ifdef YSYX_CSR_COUNTERS_EN
  localparam logic [R_W-1:0] A_MCYCLE    = R_W'(12'hB00);
  localparam logic [R_W-1:0] A_MCYCLEH   = R_W'(12'hB80);
  localparam logic [R_W-1:0] A_MINSTRET  = R_W'(12'hB02);
  localparam logic [R_W-1:0] A_MINSTRETH = R_W'(12'hB82);
  logic [63:0] mcycle, minstret;
`endif
  logic             mie, mpie, hit, we, trap, mret;
  logic [BIT_W-1:0] mtvec, mepc, mcause, mtval, mscratch, mstatus, old, wval;
  always_comb begin
    mstatus = '0;
    mstatus[12:11] = 2'b11;
    mstatus[7] = mpie;
    mstatus[3] = mie;
    old = '0;
    hit = 1'b1;
    case (bus.addr)
      A_MSTATUS:   old = mstatus;
      A_MTVEC:     old = mtvec;
      A_MSCRATCH:  old = mscratch;
      A_MEPC:      old = mepc;
      A_MCAUSE:    old = mcause;
      A_MTVAL:     old = mtval;
      A_MVENDORID: old = MVENDORID_VAL;
      A_MARCHID:   old = MARCHID_VAL;
`ifdef YSYX_CSR_COUNTERS_EN
      A_MCYCLE:    old = BIT_W'(mcycle[31:0]);
      A_MCYCLEH:   old = BIT_W'(mcycle[63:32]);
      A_MINSTRET:  old = BIT_W'(minstret[31:0]);
      A_MINSTRETH: old = BIT_W'(minstret[63:32]);
`endif
      default:     hit = 1'b0;
    endcase
    wval = bus.csr_op == 2'b01 ? bus.wsrc : bus.csr_op == 2'b10 ? (old | bus.wsrc) : (old & ~bus.wsrc);
    trap = bus.exu_valid & bus.trap_valid;
    mret = bus.exu_valid & bus.mret_valid & ~bus.trap_valid;
    // RS/RC with a zero mask are pure reads; trap and mret suppress any CSR write.
    we = bus.exu_valid & ~bus.trap_valid & ~bus.mret_valid & hit & (bus.csr_op != 2'b00)
       & (bus.csr_op == 2'b01 | bus.wsrc != '0);
  end
  assign bus.rdata_o   = old;
  assign bus.illegal_o = (bus.csr_op != 2'b00) & ~hit;
  assign bus.mtvec_o   = mtvec;
  assign bus.mepc_o    = mepc;
  assign bus.mie_o     = mie;
  always_ff @(posedge clk) begin
    if (rst) begin
      mie <= 1'b0;
      mpie <= 1'b0;
      mtvec <= RESET_VAL;
      mepc <= RESET_VAL;
      mcause <= RESET_VAL;
      mtval <= RESET_VAL;
      mscratch <= RESET_VAL;
    end else if (trap) begin
      mepc <= {bus.trap_pc[BIT_W-1:2], 2'b00};
      mcause <= bus.trap_cause;
      mtval <= bus.trap_tval;
      mpie <= mie;
      mie <= 1'b0;
    end else if (mret) begin
      mie <= mpie;
      mpie <= 1'b1;
    end else if (we) begin
      case (bus.addr)
        A_MSTATUS: begin
          mie <= wval[3];
          mpie <= wval[7];
        end
        A_MTVEC:    mtvec <= {wval[BIT_W-1:2], 2'b00};
        A_MSCRATCH: mscratch <= wval;
        A_MEPC:     mepc <= {wval[BIT_W-1:2], 2'b00};
        A_MCAUSE:   mcause <= wval;
        A_MTVAL:    mtval <= wval;
        default:    ;
      endcase
    end
  end
`ifdef YSYX_CSR_COUNTERS_EN
  // A write to one half replaces that cycle's increment; the other half is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle <= '0;
      minstret <= '0;
    end else begin
      mcycle <= (we && bus.addr == A_MCYCLE) ? {mcycle[63:32], wval[31:0]}
              : (we && bus.addr == A_MCYCLEH) ? {wval[31:0], mcycle[31:0]} : mcycle + 64'd1;
      minstret <= (we && bus.addr == A_MINSTRET) ? {minstret[63:32], wval[31:0]}
                : (we && bus.addr == A_MINSTRETH) ? {wval[31:0], minstret[31:0]}
                : minstret + 64'(bus.exu_valid & ~bus.trap_valid);
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_csr_unit.sv
// tb_ysyx_csr_unit: directed + random stimulus checked against an address/mask-table CSR model.
module tb_ysyx_csr_unit;
`ifdef YSYX_CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ysyx_csr_if bus();
  ysyx_csr_unit dut(.clk(clk), .rst(rst), .bus(bus));
  int errs = 0, checks = 0;
  logic [31:0] csr [int];
  logic [31:0] wmask [int];
  logic [63:0] mc, mi;
  int addr_pool [14] = '{'h300, 'h305, 'h340, 'h341, 'h342, 'h343, 'hF11, 'hF12,
                         'hB00, 'hB80, 'hB02, 'hB82, 'h7C0, 'h301};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit impl(input int a);
    return csr.exists(a) || (CNT && (a == 'hB00 || a == 'hB80 || a == 'hB02 || a == 'hB82));
  endfunction
  function automatic logic [31:0] rd(input int a);
    if (CNT && a == 'hB00) return mc[31:0];
    if (CNT && a == 'hB80) return mc[63:32];
    if (CNT && a == 'hB02) return mi[31:0];
    if (CNT && a == 'hB82) return mi[63:32];
    return csr.exists(a) ? csr[a] : 32'h0;
  endfunction
  task automatic model_reset();
    csr['h300] = 32'h1800;
    foreach (addr_pool[i]) if (addr_pool[i] inside {'h305, 'h340, 'h341, 'h342, 'h343}) csr[addr_pool[i]] = 32'h0;
    csr['hF11] = 32'h79737978;
    csr['hF12] = 32'h015fde77;
    mc = 64'h0;
    mi = 64'h0;
  endtask
  task automatic cyc(input bit r, input bit ev, input logic [1:0] op, input int a, input logic [31:0] w,
                     input bit tv, input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                     input bit mr);
    logic [31:0] old, nv, ms;
    logic [63:0] mcn, min;
    bit wr;
    rst = r;
    bus.exu_valid = ev;
    bus.csr_op = op;
    bus.addr = 12'(a);
    bus.wsrc = w;
    bus.trap_valid = tv;
    bus.trap_cause = cause;
    bus.trap_pc = pc;
    bus.trap_tval = tval;
    bus.mret_valid = mr;
    #4;
    if (!r) begin
      check("rdata", bus.rdata_o, impl(a) ? rd(a) : 32'h0);
      check("illegal", {31'h0, bus.illegal_o}, {31'h0, op != 2'b00 && !impl(a)});
    end
    if (r) model_reset();
    else begin
      old = rd(a);
      nv = op == 2'b01 ? w : op == 2'b10 ? (old | w) : (old & ~w);
      wr = ev && !tv && !mr && op != 2'b00 && (op == 2'b01 || w != 0) && impl(a);
      mcn = mc + 64'd1;
      min = mi + 64'(ev && !tv);
      ms = csr['h300];
      if (ev && tv) begin
        csr['h341] = pc & ~32'h3;
        csr['h342] = cause;
        csr['h343] = tval;
        csr['h300] = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
      end else if (ev && mr) csr['h300] = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
      else if (wr) begin
        if (wmask.exists(a)) csr[a] = (csr[a] & ~wmask[a]) | (nv & wmask[a]);
        if (a == 'hB00) mcn = {mc[63:32], nv};
        if (a == 'hB80) mcn = {nv, mc[31:0]};
        if (a == 'hB02) min = {mi[63:32], nv};
        if (a == 'hB82) min = {nv, mi[31:0]};
      end
      mc = mcn;
      mi = min;
    end
    @(posedge clk);
    #1;
    check("mtvec_o", bus.mtvec_o, csr['h305]);
    check("mepc_o", bus.mepc_o, csr['h341]);
    check("mie_o", {31'h0, bus.mie_o}, {31'h0, csr['h300][3]});
  endtask
  task automatic peek(input string tag, input int a, input logic [31:0] exp);
    bus.exu_valid = 1'b0;
    bus.csr_op = 2'b00;
    bus.addr = 12'(a);
    #1;
    check(tag, bus.rdata_o, exp);
  endtask
  initial begin
    wmask['h300] = 32'h88;
    wmask['h305] = 32'hFFFFFFFC;
    wmask['h340] = 32'hFFFFFFFF;
    wmask['h341] = 32'hFFFFFFFC;
    wmask['h342] = 32'hFFFFFFFF;
    wmask['h343] = 32'hFFFFFFFF;
    model_reset();
    cyc(1, 0, 2'b00, 'h300, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 'h300, 0, 0, 0, 0, 0, 0);
    peek("rst_mstatus", 'h300, 32'h1800);
    peek("mvendorid", 'hF11, 32'h79737978);
    check("rst_mtvec", bus.mtvec_o, 32'h0);
    cyc(0, 1, 2'b01, 'h305, 32'h80000103, 0, 0, 0, 0, 0);
    check("mtvec_rw", bus.mtvec_o, 32'h80000100);
    cyc(0, 1, 2'b10, 'h305, 32'h0, 0, 0, 0, 0, 0);
    check("mtvec_rs0", bus.mtvec_o, 32'h80000100);
    cyc(0, 1, 2'b11, 'h305, 32'h100, 0, 0, 0, 0, 0);
    check("mtvec_rc", bus.mtvec_o, 32'h80000000);
    cyc(0, 1, 2'b10, 'h300, 32'h8, 0, 0, 0, 0, 0);
    check("mie_set", {31'h0, bus.mie_o}, 32'h1);
    cyc(0, 1, 2'b00, 'h300, 0, 1, 32'd11, 32'h80000046, 32'h0, 0);
    check("trap_mepc", bus.mepc_o, 32'h80000044);
    check("trap_mie", {31'h0, bus.mie_o}, 32'h0);
    peek("trap_mcause", 'h342, 32'd11);
    peek("trap_mstatus", 'h300, 32'h1880);
    cyc(0, 1, 2'b00, 'h300, 0, 0, 0, 0, 0, 1);
    peek("mret_mstatus", 'h300, 32'h1888);
    cyc(0, 1, 2'b01, 'h340, 32'hABCD, 1, 32'd2, 32'h80000100, 32'h77, 1);
    peek("prio_mscratch", 'h340, 32'h0);
    peek("prio_mtval", 'h343, 32'h77);
    cyc(0, 1, 2'b10, 'h7C0, 32'h5, 0, 0, 0, 0, 0);
    bus.csr_op = 2'b10;
    bus.addr = 12'h7C0;
    #1;
    check("ill_7c0", {31'h0, bus.illegal_o}, 32'h1);
    check("ill_rdata", bus.rdata_o, 32'h0);
    if (CNT) begin
      cyc(0, 1, 2'b01, 'hB00, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      cyc(0, 1, 2'b01, 'hB80, 32'h0, 0, 0, 0, 0, 0);
      peek("mcycle_hold", 'hB00, 32'hFFFFFFFF);
      cyc(0, 0, 2'b00, 'hB00, 0, 0, 0, 0, 0, 0);
      peek("mcycle_carry", 'hB80, 32'h1);
      cyc(0, 1, 2'b01, 'hB02, 32'h0, 0, 0, 0, 0, 0);
      cyc(0, 1, 2'b01, 'hB82, 32'h0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 2'b00, 'hB02, 0, i == 4, 32'd3, 32'h80000010, 0, 0);
      peek("minstret9", 'hB02, 32'd9);
    end
    cyc(1, 1, 2'b01, 'h305, 32'h1234, 1, 32'd5, 32'h44, 32'h1, 1);
    check("midrst_mepc", bus.mepc_o, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      cyc($urandom % 100 == 0, $urandom % 4 != 0, 2'($urandom), addr_pool[$urandom % 14], w,
          $urandom % 10 == 0, $urandom, $urandom, $urandom, $urandom % 10 == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
